// File: rtl/motor_mix_arm.sv
// motor_mix_arm: throttle/PID mixer with per-motor clamping, arming FSM and radio-loss failsafe.
module motor_mix_arm #(
  parameter int NUM_MOTORS = 4,
  parameter int CH_W = 12,
  parameter int CMD_W = 13,
  parameter int MOTOR_MIN = 150,
  parameter int MOTOR_MAX = 600,
  parameter int ARM_THRESH = 500,
  parameter int THR_LOW = 50,
  parameter int FAILSAFE_CYCLES = 5000000,
  parameter logic [NUM_MOTORS-1:0] ROLL_NEG = 'b0011,
  parameter logic [NUM_MOTORS-1:0] PITCH_NEG = 'b0110,
  parameter logic [NUM_MOTORS-1:0] YAW_NEG = 'b0101
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     frame_valid,
  input  logic [CH_W-1:0]          throttle_ch,
  input  logic [CH_W-1:0]          arm_ch,
  input  logic [CMD_W-1:0]         roll_net,
  input  logic [CMD_W-1:0]         pitch_net,
  input  logic [CMD_W-1:0]         yaw_net,
  input  logic                     update,
  output logic [NUM_MOTORS*12-1:0] motor_out,
  output logic                     out_valid,
  output logic                     armed,
  output logic                     failsafe
);
  localparam int KW = $clog2(NUM_MOTORS + 1);
  localparam int WW = $clog2(FAILSAFE_CYCLES + 1);
  localparam logic signed [15:0] LO = 16'(MOTOR_MIN);
  localparam logic signed [15:0] HI = 16'(MOTOR_MAX);
  typedef enum logic [1:0] {DISARMED, ARMED, FAILSAFE} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] prev_arm_q;
  logic [WW-1:0] wd_q, wd_d;
  logic busy_q, pending_q, out_valid_q, armed_q, failsafe_q;
  logic [KW-1:0] k_q;
  logic signed [15:0] thr_q, roll_q, pitch_q, yaw_q, thr_d, sum_d;
  logic [11:0] shadow_q [NUM_MOTORS];
  logic [NUM_MOTORS*12-1:0] motor_q, shadow_flat;
  logic [31:0] thr_full;
  logic [11:0] mix_d;
  logic rn, pn, yn, commit, start, expire, arm_go;
  always_comb begin
    thr_full = 32'(throttle_ch) * 32'(MOTOR_MAX - MOTOR_MIN);
    thr_d = 16'((thr_full >> 10) + 32'(MOTOR_MIN));
    rn = 1'b0;
    pn = 1'b0;
    yn = 1'b0;
    shadow_flat = '0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      if (k_q == KW'(m)) begin
        rn = ROLL_NEG[m];
        pn = PITCH_NEG[m];
        yn = YAW_NEG[m];
      end
      shadow_flat[m*12 +: 12] = shadow_q[m];
    end
    sum_d = thr_q + (rn ? -roll_q : roll_q) + (pn ? -pitch_q : pitch_q) + (yn ? -yaw_q : yaw_q);
    mix_d = sum_d < LO ? 12'(LO) : sum_d > HI ? 12'(HI) : sum_d[11:0];
    commit = busy_q && k_q == KW'(NUM_MOTORS);
    start = (!busy_q && update) || (commit && (pending_q || update));
    // frame_valid beats an expiring watchdog on the same cycle
    expire = !frame_valid && wd_q >= WW'(FAILSAFE_CYCLES - 1);
    wd_d = frame_valid ? '0 : wd_q == WW'(FAILSAFE_CYCLES) ? wd_q : wd_q + 1'b1;
    arm_go = arm_ch > CH_W'(ARM_THRESH) && prev_arm_q < CH_W'(ARM_THRESH) && throttle_ch < CH_W'(THR_LOW);
    state_d = expire ? FAILSAFE :
              !frame_valid ? state_q :
              state_q == FAILSAFE ? DISARMED :
              state_q == ARMED ? (arm_ch < CH_W'(ARM_THRESH) ? DISARMED : ARMED) :
              (arm_go ? ARMED : DISARMED);
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= DISARMED;
      prev_arm_q <= '0;
      wd_q <= '0;
      busy_q <= 1'b0;
      pending_q <= 1'b0;
      k_q <= '0;
      out_valid_q <= 1'b0;
      motor_q <= '0;
      armed_q <= 1'b0;
      failsafe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= state_d == ARMED;
      failsafe_q <= state_d == FAILSAFE;
      wd_q <= wd_d;
      if (frame_valid) prev_arm_q <= arm_ch;
      busy_q <= start || (busy_q && !commit);
      k_q <= (busy_q && !commit) ? k_q + 1'b1 : '0;
      pending_q <= !commit && (pending_q || (busy_q && update));
      out_valid_q <= commit;
      motor_q <= state_q != ARMED ? '0 : commit ? shadow_flat : motor_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (start) begin
      thr_q <= thr_d;
      roll_q <= 16'($signed(roll_net));
      pitch_q <= 16'($signed(pitch_net));
      yaw_q <= 16'($signed(yaw_net));
    end
    for (int m = 0; m < NUM_MOTORS; m++)
      if (busy_q && !commit && k_q == KW'(m)) shadow_q[m] <= mix_d;
  end
  assign motor_out = motor_q;
  assign out_valid = out_valid_q;
  assign armed = armed_q;
  assign failsafe = failsafe_q;
endmodule

// File: tb/tb_motor_mix_arm.sv
// tb_motor_mix_arm: randomized and directed checks of mixing, clamping, arming and failsafe.
module tb_motor_mix_arm;
  logic CLK = 1'b0, rst = 1'b0, frame_valid = 1'b0, update = 1'b0;
  logic [11:0] throttle_ch = '0, arm_ch = '0;
  logic [12:0] roll_net = '0, pitch_net = '0, yaw_net = '0;
  logic [47:0] motor_out;
  logic out_valid, armed, failsafe;
  int n_tests = 0, n_fail = 0;
  int rsg [4] = '{-1, -1, 1, 1};
  int psg [4] = '{1, -1, -1, 1};
  int ysg [4] = '{-1, 1, -1, 1};

  motor_mix_arm #(.FAILSAFE_CYCLES(1000)) dut (
    .CLK(CLK), .rst(rst), .frame_valid(frame_valid), .throttle_ch(throttle_ch), .arm_ch(arm_ch),
    .roll_net(roll_net), .pitch_net(pitch_net), .yaw_net(yaw_net), .update(update),
    .motor_out(motor_out), .out_valid(out_valid), .armed(armed), .failsafe(failsafe)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [47:0] model(int th, int r, int p, int y);
    logic [47:0] res = '0;
    int t = (th * 450) / 1024 + 150;
    for (int m = 0; m < 4; m++) begin
      int s = t + rsg[m] * r + psg[m] * p + ysg[m] * y;
      s = s < 150 ? 150 : s > 600 ? 600 : s;
      res[m*12 +: 12] = 12'(s);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic frame(int a, int th);
    frame_valid = 1'b1;
    arm_ch = 12'(a);
    throttle_ch = 12'(th);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic set_in(int th, int r, int p, int y);
    throttle_ch = 12'(th);
    roll_net = 13'(r);
    pitch_net = 13'(p);
    yaw_net = 13'(y);
  endtask

  task automatic do_mix(int th, int r, int p, int y, output logic [47:0] mo, output int lat);
    set_in(th, r, p, y);
    update = 1'b1;
    tick();
    update = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    mo = motor_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (motor_out !== '0) begin n_fail++; $display("FAIL reset_motor got %h exp 0", motor_out); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got %b exp 0", armed); end
    n_tests++; if (failsafe !== 1'b0) begin n_fail++; $display("FAIL reset_failsafe got %b exp 0", failsafe); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_arm();
    int a [10] = '{0, 1000, 500, 0, 0, 1000, 0, 1000, 0, 1000};
    int t [10] = '{10, 10, 10, 10, 100, 100, 50, 50, 49, 49};
    logic e [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      frame(a[i], t[i]);
      n_tests++;
      if (armed !== e[i]) begin n_fail++; $display("FAIL arm_step%0d got %b exp %b", i, armed, e[i]); end
    end
  endtask

  task automatic test_mix();
    logic [47:0] mo;
    int lat;
    frame(1000, 10);
    do_mix(512, 20, 10, 5, mo, lat);
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL mix_latency got %0d exp 5", lat); end
    n_tests++; if (mo !== {12'd410, 12'd380, 12'd350, 12'd360}) begin n_fail++; $display("FAIL mix_basic got %h exp %h", mo, {12'd410, 12'd380, 12'd350, 12'd360}); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mix_pulse_width got %b exp 0", out_valid); end
  endtask

  task automatic test_clamp();
    logic [47:0] mo;
    int lat;
    frame(1000, 10);
    do_mix(1023, 300, 0, 0, mo, lat);
    n_tests++; if (mo !== {12'd600, 12'd600, 12'd299, 12'd299}) begin n_fail++; $display("FAIL clamp_high got %h exp %h", mo, {12'd600, 12'd600, 12'd299, 12'd299}); end
    do_mix(0, -300, 0, 0, mo, lat);
    n_tests++; if (mo !== {12'd150, 12'd150, 12'd450, 12'd450}) begin n_fail++; $display("FAIL clamp_low got %h exp %h", mo, {12'd150, 12'd150, 12'd450, 12'd450}); end
  endtask

  task automatic test_mix_random();
    logic [47:0] mo, ex;
    int lat, th, r, p, y;
    for (int i = 0; i < 16; i++) begin
      frame(1000, 10);
      th = int'($urandom_range(4095));
      r = int'($urandom_range(1200)) - 600;
      p = int'($urandom_range(1200)) - 600;
      y = int'($urandom_range(8191)) - 4096;
      ex = model(th, r, p, y);
      do_mix(th, r, p, y, mo, lat);
      n_tests++;
      if (mo !== ex || lat != 5) begin n_fail++; $display("FAIL mix_rand%0d got %h lat %0d exp %h lat 5", i, mo, lat, ex); end
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] got [$];
    int when [$];
    frame(1000, 10);
    for (int c = 0; c < 30; c++) begin
      update = (c == 0 || c == 2 || c == 4);
      if (c < 5) set_in(700, 40, -25, 12);
      else if (c == 5) set_in(300, -60, 33, -7);
      else set_in(900, 5, 5, 5);
      tick();
      if (out_valid) begin got.push_back(motor_out); when.push_back(c); end
    end
    update = 1'b0;
    n_tests++;
    if (got.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", got.size()); end
    else begin
      n_tests++; if (got[0] !== model(700, 40, -25, 12) || when[0] != 5) begin n_fail++; $display("FAIL b2b_first got %h at %0d exp %h at 5", got[0], when[0], model(700, 40, -25, 12)); end
      n_tests++; if (got[1] !== model(300, -60, 33, -7) || when[1] != 10) begin n_fail++; $display("FAIL b2b_second got %h at %0d exp %h at 10", got[1], when[1], model(300, -60, 33, -7)); end
    end
  endtask

  task automatic test_disarm_mid();
    int pulses = 0;
    frame(1000, 10);
    n_tests++; if (motor_out === '0) begin n_fail++; $display("FAIL disarm_pre got %h exp nonzero", motor_out); end
    set_in(600, 10, 10, 10);
    for (int c = 0; c < 12; c++) begin
      update = (c == 0);
      frame_valid = (c == 2);
      arm_ch = '0;
      tick();
      if (c == 2) begin n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL disarm_state got %b exp 0", armed); end end
      if (c == 3) begin n_tests++; if (motor_out !== '0) begin n_fail++; $display("FAIL disarm_clear got %h exp 0", motor_out); end end
      if (out_valid) begin
        pulses++;
        n_tests++; if (motor_out !== '0 || c != 5) begin n_fail++; $display("FAIL disarm_commit got %h at %0d exp 0 at 5", motor_out, c); end
      end
    end
    update = 1'b0;
    frame_valid = 1'b0;
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL disarm_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_frame_wins();
    frame(0, 10);
    frame(1000, 10);
    repeat (999) tick();
    frame(1000, 10);
    n_tests++; if (failsafe !== 1'b0 || armed !== 1'b1) begin n_fail++; $display("FAIL frame_wins got fs %b armed %b exp fs 0 armed 1", failsafe, armed); end
  endtask

  task automatic test_failsafe();
    int n = 0;
    frame(1000, 10);
    while (!failsafe && n < 1100) begin
      tick();
      n++;
    end
    n_tests++; if (n != 1000) begin n_fail++; $display("FAIL fs_timing got %0d exp 1000", n); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL fs_armed got %b exp 0", armed); end
    tick();
    n_tests++; if (motor_out !== '0) begin n_fail++; $display("FAIL fs_motor got %h exp 0", motor_out); end
    frame(1000, 10);
    n_tests++; if (failsafe !== 1'b0 || armed !== 1'b0) begin n_fail++; $display("FAIL fs_exit got fs %b armed %b exp 0 0", failsafe, armed); end
    frame(1000, 10);
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL fs_no_edge got %b exp 0", armed); end
    frame(0, 10);
    frame(1000, 10);
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL fs_rearm got %b exp 1", armed); end
  endtask

  task automatic test_reset_mid_sweep();
    int seen = 0;
    set_in(500, 1, 2, 3);
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_abort got %0d pulses exp 0", seen); end
    n_tests++; if (armed !== 1'b0 || motor_out !== '0) begin n_fail++; $display("FAIL rst_state got armed %b motor %h exp 0 0", armed, motor_out); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_mix();
    test_clamp();
    test_mix_random();
    test_back_to_back();
    test_disarm_mid();
    test_frame_wins();
    test_failsafe();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/motor_mix_arm.md
Name: motor_mix_arm

Overview:
Parametrised motor mixer and arming supervisor for an N-rotor airframe. It sits between the PPM decoder and PID loops upstream and the PWM encoder downstream. It scales the throttle stick and mixes roll, pitch and yaw PID outputs into per-motor commands using configurable sign masks, one motor per cycle, then clamps the results. It also runs an arming FSM with a radio-loss failsafe watchdog that forces all motors to zero.

Parameters:
NUM_MOTORS, 4, number of motor outputs (2..8)
CH_W, 12, width of stick channels
CMD_W, 13, width of signed PID outputs
MOTOR_MIN, 150, minimum armed motor command
MOTOR_MAX, 600, maximum motor command
ARM_THRESH, 500, arm-channel threshold
THR_LOW, 50, raw throttle must be strictly below this to arm
FAILSAFE_CYCLES, 5000000, CLK cycles without frame_valid before failsafe (100 ms at 50 MHz)
ROLL_NEG, 4'b0011, bit m=1: subtract roll for motor m
PITCH_NEG, 4'b0110, bit m=1: subtract pitch for motor m
YAW_NEG, 4'b0101, bit m=1: subtract yaw for motor m

Ports:
CLK  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
frame_valid  in  1  one-cycle pulse when a new PPM frame is decoded
throttle_ch  in  CH_W  raw throttle stick, unsigned
arm_ch  in  CH_W  raw arm switch channel, unsigned
roll_net  in  CMD_W  signed roll PID output
pitch_net  in  CMD_W  signed pitch PID output
yaw_net  in  CMD_W  signed yaw PID output
update  in  1  one-cycle pulse: PID outputs are new
motor_out  out  NUM_MOTORS*12  packed motor commands; motor m occupies bits [12m+11:12m]
out_valid  out  1  one-cycle pulse when motor_out is committed
armed  out  1  high in the ARMED state
failsafe  out  1  high in the FAILSAFE state

Behaviour:
- Reset: FSM goes to DISARMED. motor_out=0, out_valid=0, armed=0, failsafe=0, prev_arm=0, watchdog=0, busy=0, pending=0.
- Throttle scaling: thr = ((throttle_ch*(MOTOR_MAX-MOTOR_MIN))>>10)+MOTOR_MIN. Compute unsigned, then treat the result as a 16-bit signed value.
- Sweep start: update while idle latches thr, roll, pitch and yaw, and sets busy.
- Sweep, cycle k=0..NUM_MOTORS-1: sum_k = thr ±roll ±pitch ±yaw in 16-bit signed arithmetic, with signs from the *_NEG bits. Clamp sum_k to [MOTOR_MIN, MOTOR_MAX] and write it to shadow[k].
- Commit: on the cycle after the last motor, copy shadow into motor_out if armed, else write zeros. Pulse out_valid and clear busy.
- Latency: update at cycle t gives out_valid at t+NUM_MOTORS+1.
- update while busy sets pending; further updates while pending are dropped. On commit with pending set, clear pending and restart the sweep next cycle with inputs latched at that cycle.
- FSM states: DISARMED, ARMED, FAILSAFE. Arm-channel evaluation happens only on frame_valid; prev_arm <= arm_ch on every frame_valid.
- DISARMED->ARMED: frame_valid && arm_ch>ARM_THRESH && prev_arm<ARM_THRESH && throttle_ch<THR_LOW.
- ARMED->DISARMED: frame_valid && arm_ch<ARM_THRESH. arm_ch==ARM_THRESH causes no transition.
- Watchdog: cleared on frame_valid, otherwise increments, saturating at FAILSAFE_CYCLES. Reaching FAILSAFE_CYCLES from any state moves the FSM to FAILSAFE.
- FAILSAFE->DISARMED: on the next frame_valid, with prev_arm updated from that frame. Re-arming therefore needs a fresh low-to-high arm edge.
- frame_valid on the same cycle the watchdog would expire: frame_valid wins, watchdog clears, no failsafe.
- Leaving ARMED for any reason: motor_out is cleared to 0 the next cycle. An in-flight sweep still completes and commits zeros with out_valid.
- rst mid-sweep: the sweep aborts with no out_valid.

Test Plan:
- Arm: arm_ch 0 then 1000 with throttle_ch=10, each on a frame_valid -> armed=1 after the second frame. Repeat with throttle_ch=100 -> armed stays 0.
- Mix: armed, throttle_ch=512 (thr=375), roll=+20, pitch=+10, yaw=+5, update -> out_valid 5 cycles later; motor_out m0..m3 = 360, 350, 380, 410.
- Clamp: throttle_ch=1023 (thr=599), roll=+300, pitch=yaw=0 -> 299, 299, 600, 600. throttle_ch=0, roll=-300 -> 450, 450, 150, 150.
- Failsafe (FAILSAFE_CYCLES=1000): armed, stop frame_valid -> failsafe=1 and armed=0 at cycle 1000, motor_out=0 the next cycle. A frame with arm_ch=1000 -> DISARMED and not armed; arm low then high again -> re-armed.
- Back-to-back: three update pulses spaced 1 cycle apart -> exactly two out_valid pulses; the second sweep uses inputs present at the first commit.
- Disarm mid-sweep: frame_valid with arm_ch=0 during sweep cycle 1 -> motor_out=0 next cycle; out_valid still pulses with zeros.
